// File: rtl/parking_pkg.sv
// Shared types and default timing constants for the parking sensor front end.
package parking_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned LOCKOUT_CYCLES_DEF  = 8;

    typedef logic [1:0] slot_t;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY_PULSE,
        EXIT_PULSE,
        DROP,
        LOCKOUT
    } arb_state_t;

endpackage

// File: rtl/parking_sensor_conditioner_if.sv
// Raw sensor inputs and conditioned event outputs of the parking front end.
interface parking_sensor_conditioner_if;
    import parking_pkg::*;

    logic  entry_raw;
    logic  exit_raw;
    slot_t switch_raw;
    logic  full;
    logic  entry_sensor;
    logic  exit_sensor;
    slot_t switch;
    logic  entry_dropped;
    logic  busy;

    modport master (
        output entry_raw, exit_raw, switch_raw, full,
        input  entry_sensor, exit_sensor, switch, entry_dropped, busy
    );

    modport slave (
        input  entry_raw, exit_raw, switch_raw, full,
        output entry_sensor, exit_sensor, switch, entry_dropped, busy
    );

endinterface

// File: rtl/parking_sensor_conditioner_debounce.sv
// One beam channel: 2-FF synchroniser, stability counter and rising-edge strobe.
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    logic       sync1;
    logic       sync2;
    logic       stable;
    logic       stable_q;
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            // The flip happens on the edge where the count would reach DEBOUNCE_CYCLES.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == 4'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign rise = stable & ~stable_q;

endmodule

// File: rtl/parking_sensor_conditioner.sv
// Conditions entry/exit beams and the slot selector into spaced, non-overlapping event pulses.
module parking_sensor_conditioner
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF
) (
    input logic                          clk,
    input logic                          reset,
    parking_sensor_conditioner_if.slave  bus
);

    logic       entry_rise;
    logic       exit_rise;
    slot_t      switch_sync1;
    slot_t      switch_sync2;
    logic       entry_pend;
    logic       exit_pend;
    logic [3:0] lock_cnt;
    arb_state_t state;

    logic decide;
    logic grant_exit;
    logic grant_entry;
    logic grant_drop;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.entry_raw),
        .rise  (entry_rise)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.exit_raw),
        .rise  (exit_rise)
    );

    // The last LOCKOUT cycle arbitrates like IDLE so back-to-back pulses sit LOCKOUT_CYCLES+1 apart.
    always_comb begin
        decide      = (state == IDLE) ||
                      ((state == LOCKOUT) && (lock_cnt == 4'(LOCKOUT_CYCLES - 1)));
        grant_exit  = decide && exit_pend;
        grant_entry = decide && !exit_pend && entry_pend && !bus.full;
        grant_drop  = decide && !exit_pend && entry_pend && bus.full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            lock_cnt          <= '0;
            entry_pend        <= 1'b0;
            exit_pend         <= 1'b0;
            switch_sync1      <= '0;
            switch_sync2      <= '0;
            bus.switch        <= '0;
            bus.entry_sensor  <= 1'b0;
            bus.exit_sensor   <= 1'b0;
            bus.entry_dropped <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            switch_sync1      <= bus.switch_raw;
            switch_sync2      <= switch_sync1;
            exit_pend         <= grant_exit ? 1'b0 : (exit_pend | exit_rise);
            entry_pend        <= (grant_entry || grant_drop) ? 1'b0 : (entry_pend | entry_rise);
            bus.entry_sensor  <= grant_entry;
            bus.exit_sensor   <= grant_exit;
            bus.entry_dropped <= grant_drop;

            case (state)
                IDLE, LOCKOUT: begin
                    if (grant_exit) begin
                        state      <= EXIT_PULSE;
                        bus.switch <= switch_sync2;
                        bus.busy   <= 1'b1;
                    end else if (grant_entry) begin
                        state    <= ENTRY_PULSE;
                        bus.busy <= 1'b1;
                    end else if (grant_drop) begin
                        state    <= DROP;
                        bus.busy <= 1'b1;
                    end else if (decide) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        lock_cnt <= lock_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= LOCKOUT;
                    lock_cnt <= '0;
                    bus.busy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_sensor_conditioner.sv
// Directed bench for parking_sensor_conditioner with default timing (debounce 4, lockout 8).
module tb_parking_sensor_conditioner;
    import parking_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    parking_sensor_conditioner_if ifc ();

    parking_sensor_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .LOCKOUT_CYCLES  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_entry   = 0;
    int    n_exit    = 0;
    int    n_drop    = 0;
    int    n_busy    = 0;
    int    n_overlap = 0;
    int    t_entry [64];
    int    t_exit  [64];
    int    t_drop  [64];
    slot_t sw_exit [64];

    always @(negedge clk) begin
        if (ifc.entry_sensor === 1'b1) begin
            t_entry[n_entry[5:0]] = cyc;
            n_entry++;
        end
        if (ifc.exit_sensor === 1'b1) begin
            t_exit[n_exit[5:0]]  = cyc;
            sw_exit[n_exit[5:0]] = ifc.switch;
            n_exit++;
        end
        if (ifc.entry_dropped === 1'b1) begin
            t_drop[n_drop[5:0]] = cyc;
            n_drop++;
        end
        if (ifc.busy === 1'b1) n_busy++;
        if ((ifc.entry_sensor === 1'b1) && (ifc.exit_sensor === 1'b1)) n_overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int t0, t1;
    int b_entry, b_exit, b_drop, b_busy, b_ovl;

    task automatic mark();
        b_entry = n_entry;
        b_exit  = n_exit;
        b_drop  = n_drop;
        b_busy  = n_busy;
        b_ovl   = n_overlap;
    endtask

    initial begin
        reset          = 1'b1;
        ifc.entry_raw  = 1'b0;
        ifc.exit_raw   = 1'b0;
        ifc.switch_raw = 2'b00;
        ifc.full       = 1'b0;
        step(3);
        check("rst_entry_sensor", 32'(ifc.entry_sensor), 0);
        check("rst_exit_sensor", 32'(ifc.exit_sensor), 0);
        check("rst_entry_dropped", 32'(ifc.entry_dropped), 0);
        check("rst_busy", 32'(ifc.busy), 0);
        check("rst_switch", 32'(ifc.switch), 0);
        reset = 1'b0;
        step(2);

        // Clean entry
        mark();
        ifc.entry_raw = 1'b1;
        t0 = cyc + 1;
        step(20);
        ifc.entry_raw = 1'b0;
        step(15);
        check("clean_entry_count", 32'(n_entry - b_entry), 1);
        check("clean_entry_time", 32'(t_entry[b_entry[5:0]]), 32'(t0 + 7));
        check("clean_busy_cycles", 32'(n_busy - b_busy), 9);
        check("clean_no_exit", 32'(n_exit - b_exit), 0);
        check("clean_no_drop", 32'(n_drop - b_drop), 0);

        // Glitch rejection: 3-cycle exit pulses never confirm
        mark();
        repeat (5) begin
            ifc.exit_raw = 1'b1;
            step(3);
            ifc.exit_raw = 1'b0;
            step(3);
        end
        step(10);
        check("glitch_no_exit", 32'(n_exit - b_exit), 0);
        check("glitch_busy_cycles", 32'(n_busy - b_busy), 0);

        // Simultaneous arrival, slot 2
        ifc.switch_raw = 2'b10;
        step(3);
        mark();
        ifc.entry_raw = 1'b1;
        ifc.exit_raw  = 1'b1;
        t0 = cyc + 1;
        step(12);
        ifc.switch_raw = 2'b01;
        step(20);
        ifc.entry_raw = 1'b0;
        ifc.exit_raw  = 1'b0;
        step(15);
        check("sim_exit_count", 32'(n_exit - b_exit), 1);
        check("sim_exit_time", 32'(t_exit[b_exit[5:0]]), 32'(t0 + 7));
        check("sim_exit_switch", 32'(sw_exit[b_exit[5:0]]), 2);
        check("sim_entry_count", 32'(n_entry - b_entry), 1);
        check("sim_entry_time", 32'(t_entry[b_entry[5:0]]), 32'(t0 + 16));
        check("sim_no_overlap", 32'(n_overlap - b_ovl), 0);
        check("sim_switch_held", 32'(ifc.switch), 2);

        // Full lot: entry dropped, later exit still pulsed
        ifc.full = 1'b1;
        step(2);
        mark();
        ifc.entry_raw = 1'b1;
        t0 = cyc + 1;
        step(20);
        ifc.exit_raw = 1'b1;
        t1 = cyc + 1;
        step(15);
        ifc.exit_raw  = 1'b0;
        ifc.entry_raw = 1'b0;
        ifc.full      = 1'b0;
        step(15);
        check("full_drop_count", 32'(n_drop - b_drop), 1);
        check("full_drop_time", 32'(t_drop[b_drop[5:0]]), 32'(t0 + 7));
        check("full_no_entry", 32'(n_entry - b_entry), 0);
        check("full_exit_count", 32'(n_exit - b_exit), 1);
        check("full_exit_time", 32'(t_exit[b_exit[5:0]]), 32'(t1 + 7));
        check("full_exit_switch", 32'(sw_exit[b_exit[5:0]]), 1);

        // Second exit debounced during LOCKOUT is captured
        mark();
        ifc.exit_raw = 1'b1;
        t0 = cyc + 1;
        step(4);
        ifc.exit_raw = 1'b0;
        step(4);
        ifc.exit_raw = 1'b1;
        step(25);
        ifc.exit_raw = 1'b0;
        step(15);
        check("lock_exit_count", 32'(n_exit - b_exit), 2);
        check("lock_exit_first", 32'(t_exit[b_exit[5:0]]), 32'(t0 + 7));
        check("lock_exit_spacing", 32'(t_exit[6'(b_exit + 1)] - t_exit[b_exit[5:0]]), 9);

        // Entry re-arrival while its flag is still pending is lost
        mark();
        ifc.exit_raw  = 1'b1;
        ifc.entry_raw = 1'b1;
        t0 = cyc + 1;
        step(4);
        ifc.entry_raw = 1'b0;
        step(4);
        ifc.entry_raw = 1'b1;
        step(25);
        ifc.entry_raw = 1'b0;
        ifc.exit_raw  = 1'b0;
        step(15);
        check("lost_exit_time", 32'(t_exit[b_exit[5:0]]), 32'(t0 + 7));
        check("lost_entry_count", 32'(n_entry - b_entry), 1);
        check("lost_entry_time", 32'(t_entry[b_entry[5:0]]), 32'(t0 + 16));

        // Reset mid-LOCKOUT with entry pending; exit held through release
        ifc.switch_raw = 2'b11;
        step(3);
        mark();
        ifc.entry_raw = 1'b1;
        ifc.exit_raw  = 1'b1;
        t0 = cyc + 1;
        step(10);
        reset         = 1'b1;
        ifc.entry_raw = 1'b0;
        step(1);
        check("rstmid_busy", 32'(ifc.busy), 0);
        check("rstmid_entry_sensor", 32'(ifc.entry_sensor), 0);
        check("rstmid_exit_sensor", 32'(ifc.exit_sensor), 0);
        check("rstmid_switch", 32'(ifc.switch), 0);
        step(2);
        reset = 1'b0;
        t1 = cyc + 1;
        step(30);
        check("rstmid_exit_count", 32'(n_exit - b_exit), 2);
        check("rstmid_exit_first", 32'(t_exit[b_exit[5:0]]), 32'(t0 + 7));
        check("rstmid_exit_release", 32'(t_exit[6'(b_exit + 1)]), 32'(t1 + 7));
        check("rstmid_exit_switch", 32'(sw_exit[6'(b_exit + 1)]), 3);
        check("rstmid_entry_discarded", 32'(n_entry - b_entry), 0);
        check("rstmid_idle_after", 32'(ifc.busy), 0);
        ifc.exit_raw = 1'b0;
        step(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
